// File: rtl/uart_cmd_sequencer_if.sv
// Host-side byte stream in, command header and payload handshake out.
interface uart_cmd_sequencer_if;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic [7:0]  cmd;
    logic [31:0] byte_count;
    logic        cmd_valid;
    logic [7:0]  payload_data;
    logic        payload_valid;
    logic        payload_ack;
    logic        busy;
    logic        done;
    logic        overrun;
    logic        timeout;

    modport master (
        input  rx_data, rx_ready, payload_ack,
        output cmd, byte_count, cmd_valid, payload_data, payload_valid,
               busy, done, overrun, timeout
    );

    modport slave (
        output rx_data, rx_ready, payload_ack,
        input  cmd, byte_count, cmd_valid, payload_data, payload_valid,
               busy, done, overrun, timeout
    );
endinterface

// File: rtl/uart_cmd_sequencer.sv
// Parses sync word, command, 32-bit big-endian length and payload from the UART
// byte stream; streams payload over a valid/ack holding register.
module uart_cmd_sequencer #(
    parameter logic [31:0] SYNC_WORD      = 32'hDEADBEEF,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  reset,
    uart_cmd_sequencer_if.master  bus
);
    localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_SYNC, ST_CMD, ST_LEN, ST_PAYLOAD, ST_DRAIN
    } state_t;

    state_t               state, state_next;
    logic [1:0]           match, match_next, match_adv;
    logic [1:0]           len_idx, len_idx_next;
    logic [7:0]           cmd, cmd_next;
    logic [31:0]          count, count_next;
    logic [31:0]          remaining, remaining_next;
    logic [7:0]           pdata, pdata_next;
    logic                 pvalid, pvalid_next;
    logic [TIMER_W-1:0]   timer, timer_next;
    logic                 busy, busy_next;
    logic                 cmd_valid, cmd_valid_next;
    logic                 done, done_next;
    logic                 overrun, overrun_next;
    logic                 timeout, timeout_next;
    logic                 sync_hit;
    logic                 drain_exit;

    function automatic logic [7:0] sync_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    sync_byte = SYNC_WORD[31:24];
            2'd1:    sync_byte = SYNC_WORD[23:16];
            2'd2:    sync_byte = SYNC_WORD[15:8];
            default: sync_byte = SYNC_WORD[7:0];
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_SYNC;
            match     <= 2'd0;
            len_idx   <= 2'd0;
            cmd       <= 8'd0;
            count     <= 32'd0;
            remaining <= 32'd0;
            pdata     <= 8'd0;
            pvalid    <= 1'b0;
            timer     <= '0;
            busy      <= 1'b0;
            cmd_valid <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_next;
            match     <= match_next;
            len_idx   <= len_idx_next;
            cmd       <= cmd_next;
            count     <= count_next;
            remaining <= remaining_next;
            pdata     <= pdata_next;
            pvalid    <= pvalid_next;
            timer     <= timer_next;
            busy      <= busy_next;
            cmd_valid <= cmd_valid_next;
            done      <= done_next;
            overrun   <= overrun_next;
            timeout   <= timeout_next;
        end
    end

    always_comb begin
        state_next     = state;
        match_next     = match;
        len_idx_next   = len_idx;
        cmd_next       = cmd;
        count_next     = count;
        remaining_next = remaining;
        pdata_next     = pdata;
        pvalid_next    = pvalid;
        timer_next     = timer;
        cmd_valid_next = 1'b0;
        done_next      = 1'b0;
        overrun_next   = 1'b0;
        timeout_next   = 1'b0;
        sync_hit       = 1'b0;
        drain_exit     = !pvalid || bus.payload_ack;

        // Sync matcher; a mismatching lead byte restarts the match at 1
        if (bus.rx_data == sync_byte(match)) begin
            sync_hit  = (match == 2'd3);
            match_adv = match + 2'd1;
        end else begin
            match_adv = (bus.rx_data == SYNC_WORD[31:24]) ? 2'd1 : 2'd0;
        end

        unique case (state)
            ST_SYNC: begin
                if (bus.rx_ready) begin
                    match_next = match_adv;
                    if (sync_hit) state_next = ST_CMD;
                end
            end
            ST_CMD: begin
                if (bus.rx_ready) begin
                    cmd_next     = bus.rx_data;
                    len_idx_next = 2'd0;
                    state_next   = ST_LEN;
                end
            end
            ST_LEN: begin
                if (bus.rx_ready) begin
                    count_next   = {count[23:0], bus.rx_data};
                    len_idx_next = len_idx + 2'd1;
                    if (len_idx == 2'd3) begin
                        cmd_valid_next = 1'b1;
                        if (count_next == 32'd0) begin
                            done_next  = 1'b1;
                            match_next = 2'd0;
                            state_next = ST_SYNC;
                        end else begin
                            remaining_next = count_next;
                            state_next     = ST_PAYLOAD;
                        end
                    end
                end
            end
            ST_PAYLOAD: begin
                if (bus.rx_ready) begin
                    if (!pvalid || bus.payload_ack) begin
                        pdata_next  = bus.rx_data;
                        pvalid_next = 1'b1;
                    end else begin
                        overrun_next = 1'b1;
                    end
                    remaining_next = remaining - 32'd1;
                    if (remaining == 32'd1) state_next = ST_DRAIN;
                end else if (bus.payload_ack) begin
                    pvalid_next = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (drain_exit) begin
                    pvalid_next = 1'b0;
                    done_next   = 1'b1;
                    state_next  = ST_SYNC;
                end
                // Bytes landing here already belong to the next sync search
                if (bus.rx_ready) begin
                    match_next = match_adv;
                    if (sync_hit && drain_exit) state_next = ST_CMD;
                end
            end
            default: state_next = ST_SYNC;
        endcase

        // Inter-byte idle timer, only armed inside a packet header or payload
        if (bus.rx_ready) begin
            timer_next = '0;
        end else if (state == ST_CMD || state == ST_LEN || state == ST_PAYLOAD) begin
            if (timer == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
                timeout_next = 1'b1;
                pvalid_next  = 1'b0;
                match_next   = 2'd0;
                state_next   = ST_SYNC;
                timer_next   = '0;
            end else begin
                timer_next = timer + TIMER_W'(1);
            end
        end

        busy_next = (state_next != ST_SYNC);
    end

    assign bus.cmd           = cmd;
    assign bus.byte_count    = count;
    assign bus.cmd_valid     = cmd_valid;
    assign bus.payload_data  = pdata;
    assign bus.payload_valid = pvalid;
    assign bus.busy          = busy;
    assign bus.done          = done;
    assign bus.overrun       = overrun;
    assign bus.timeout       = timeout;
endmodule
